// File: rtl/db_store_drain_pkg.sv
// Shared definitions for the deblocking store-buffer drain controller:
// FSM state encoding and default widths.
package db_store_drain_pkg;

    localparam int DW_DEF  = 128;
    localparam int BAW_DEF = 6;
    localparam int EAW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } drain_state_e;

endpackage

// File: rtl/db_store_drain_fifo2.sv
// Two-entry first-word-fall-through FIFO between the buffer read port and the
// external write channel; a word arriving into an empty FIFO is visible at once.
module db_drain_fifo2 #(
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [DW-1:0] rdata_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wptr_q;
    logic          rptr_q;
    logic [1:0]    count_q;
    logic          empty;
    logic          store;
    logic          take;

    assign empty = (count_q == 2'd0);
    // A push that is popped in the same cycle while empty bypasses storage.
    assign store = push_i & ~(empty & pop_i);
    assign take  = pop_i & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (store) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ~wptr_q;
            end
            if (take) begin
                rptr_q <= ~rptr_q;
            end
            count_q <= count_q + {1'b0, store} - {1'b0, take};
        end
    end

    assign valid_o = ~empty | push_i;
    assign rdata_o = empty ? (push_i ? wdata_i : '0) : mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/db_store_drain.sv
// Drains a contiguous (wrapping) run of words from the deblocking store buffer
// into one external-memory write burst with valid/ready back-pressure.
module db_store_drain
    import db_store_drain_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int BAW = BAW_DEF,
    parameter int EAW = EAW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [BAW-1:0] base_raddr_i,
    input  logic [BAW:0]   word_num_i,
    input  logic [EAW-1:0] ext_addr_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           rd_o,
    output logic [BAW-1:0] raddr_o,
    input  logic [DW-1:0]  rdata_i,
    output logic           ext_req_o,
    output logic [EAW-1:0] ext_addr_o,
    output logic [BAW:0]   ext_len_o,
    input  logic           ext_ack_i,
    output logic           ext_wvalid_o,
    output logic [DW-1:0]  ext_wdata_o,
    output logic           ext_wlast_o,
    input  logic           ext_wready_i
);

    localparam logic [BAW:0] ONE = {{BAW{1'b0}}, 1'b1};

    // Handshake: a word transfers on a cycle where ext_wvalid_o and ext_wready_i
    // are both high; once raised, valid and data hold until that transfer.
    drain_state_e   state_q;
    logic           busy_q;
    logic           done_q;
    logic           req_q;
    logic [BAW-1:0] base_q;
    logic [BAW:0]   num_q;
    logic [EAW-1:0] ext_addr_q;
    logic [BAW:0]   rcnt_q;
    logic [BAW:0]   wcnt_q;
    logic           inflight_q;

    logic [1:0]     fifo_count;
    logic           fifo_valid;
    logic [DW-1:0]  fifo_data;
    logic           pop;
    logic           last;
    logic           rd;
    logic [2:0]     occ;

    db_drain_fifo2 #(.DW(DW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .wdata_i (rdata_i),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .rdata_o (fifo_data),
        .count_o (fifo_count)
    );

    assign pop  = fifo_valid & ext_wready_i;
    assign last = fifo_valid & (wcnt_q == (num_q - ONE));
    // Words held or on their way, after this cycle's pop; capped at two.
    assign occ  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd   = (state_q == ST_DATA) && (rcnt_q < num_q) && (occ < 3'd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            req_q      <= 1'b0;
            base_q     <= '0;
            num_q      <= '0;
            ext_addr_q <= '0;
            rcnt_q     <= '0;
            wcnt_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd;
            if (rd) begin
                rcnt_q <= rcnt_q + ONE;
            end
            if (pop) begin
                wcnt_q <= wcnt_q + ONE;
            end
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (word_num_i != '0) begin
                            base_q     <= base_raddr_i;
                            num_q      <= word_num_i;
                            ext_addr_q <= ext_addr_i;
                            rcnt_q     <= '0;
                            wcnt_q     <= '0;
                            req_q      <= 1'b1;
                            state_q    <= ST_REQ;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (ext_ack_i) begin
                        req_q   <= 1'b0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (pop && last) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Zero-length drains arrive here with done_q low and pulse it next.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign rd_o         = rd;
    assign raddr_o      = base_q + rcnt_q[BAW-1:0];
    assign ext_req_o    = req_q;
    assign ext_addr_o   = ext_addr_q;
    assign ext_len_o    = num_q;
    assign ext_wvalid_o = fifo_valid;
    assign ext_wdata_o  = fifo_data;
    assign ext_wlast_o  = last;

endmodule

// File: tb/tb_db_store_drain.sv
// Directed bench for db_store_drain: buffer model, ready driver, stream
// scoreboard with expected queue, and cycle-exact control checks.
module tb_db_store_drain;

    localparam int DW  = 128;
    localparam int BAW = 6;
    localparam int EAW = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_i = 1'b0;
    logic [BAW-1:0] base_raddr_i = '0;
    logic [BAW:0]   word_num_i = '0;
    logic [EAW-1:0] ext_addr_i = '0;
    logic           busy_o;
    logic           done_o;
    logic           rd_o;
    logic [BAW-1:0] raddr_o;
    logic [DW-1:0]  rdata_i = '0;
    logic           ext_req_o;
    logic [EAW-1:0] ext_addr_o;
    logic [BAW:0]   ext_len_o;
    logic           ext_ack_i = 1'b0;
    logic           ext_wvalid_o;
    logic [DW-1:0]  ext_wdata_o;
    logic           ext_wlast_o;
    logic           ext_wready_i = 1'b1;

    db_store_drain #(.DW(DW), .BAW(BAW), .EAW(EAW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .base_raddr_i (base_raddr_i),
        .word_num_i   (word_num_i),
        .ext_addr_i   (ext_addr_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .rd_o         (rd_o),
        .raddr_o      (raddr_o),
        .rdata_i      (rdata_i),
        .ext_req_o    (ext_req_o),
        .ext_addr_o   (ext_addr_o),
        .ext_len_o    (ext_len_o),
        .ext_ack_i    (ext_ack_i),
        .ext_wvalid_o (ext_wvalid_o),
        .ext_wdata_o  (ext_wdata_o),
        .ext_wlast_o  (ext_wlast_o),
        .ext_wready_i (ext_wready_i)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- buffer model ----------------
    function automatic logic [DW-1:0] word_of(input int i);
        return {32'hDB00_0000 + 32'(i), 32'(i * 7 + 3), ~32'(i), 32'(i)};
    endfunction

    logic [DW-1:0] buf_mem [64];
    initial for (int i = 0; i < 64; i++) buf_mem[i] = word_of(i);
    always @(posedge clk) if (rd_o) rdata_i <= buf_mem[raddr_o];

    // ---------------- ready driver ----------------
    bit bp_mode  = 1'b0;
    int lo_start = -100;
    initial forever begin
        @(posedge clk);
        #1;
        if (!bp_mode) ext_wready_i = 1'b1;
        else if (cyc >= lo_start && cyc < lo_start + 5) ext_wready_i = 1'b0;
        else ext_wready_i = 1'($urandom_range(0, 1));
    end

    // ---------------- scoreboard / monitor ----------------
    logic [DW-1:0] exp_q[$];
    int            exp_base = 0;
    int            rd_idx   = 0;
    int            hs_cnt   = 0;
    int            first_hs = -1;
    int            last_hs  = -1;
    int            outst    = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            outst      = 0;
            prev_stall = 1'b0;
        end else begin
            automatic bit pop = ext_wvalid_o & ext_wready_i;
            if (prev_stall) begin
                check("hold_valid", 128'(ext_wvalid_o), 128'd1);
                check("hold_data", ext_wdata_o, prev_data);
            end
            if (rd_o) begin
                check("rd_limit", 128'((outst - int'(pop)) < 2), 128'd1);
                check("raddr", 128'(raddr_o), 128'((exp_base + rd_idx) % 64));
                rd_idx++;
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 128'd1, 128'd0);
                end else begin
                    automatic logic [DW-1:0] e = exp_q.pop_front();
                    check("wdata", ext_wdata_o, e);
                    check("wlast", 128'(ext_wlast_o), 128'(exp_q.size() == 0));
                end
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                hs_cnt++;
            end
            outst      = outst + int'(rd_o) - int'(pop);
            prev_stall = ext_wvalid_o & ~ext_wready_i;
            prev_data  = ext_wdata_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 128'(busy_o), 128'd0);
        check({tag, "_done"}, 128'(done_o), 128'd0);
        check({tag, "_rd"}, 128'(rd_o), 128'd0);
        check({tag, "_raddr"}, 128'(raddr_o), 128'd0);
        check({tag, "_req"}, 128'(ext_req_o), 128'd0);
        check({tag, "_addr"}, 128'(ext_addr_o), 128'd0);
        check({tag, "_len"}, 128'(ext_len_o), 128'd0);
        check({tag, "_wvalid"}, 128'(ext_wvalid_o), 128'd0);
        check({tag, "_wdata"}, ext_wdata_o, 128'd0);
        check({tag, "_wlast"}, 128'(ext_wlast_o), 128'd0);
    endtask

    task automatic arm_scoreboard(input int base, input int num);
        exp_q.delete();
        for (int i = 0; i < num; i++) exp_q.push_back(word_of((base + i) % 64));
        exp_base = base;
        rd_idx   = 0;
        hs_cnt   = 0;
        first_hs = -1;
        last_hs  = -1;
    endtask

    task automatic run_drain(input int base, input int num, input logic [31:0] ea,
                             input int ack_dly, input bit bp, input bit poke);
        arm_scoreboard(base, num);
        bp_mode      = bp;
        lo_start     = cyc + ack_dly + 4;
        start_i      = 1'b1;
        base_raddr_i = BAW'(base);
        word_num_i   = (BAW + 1)'(num);
        ext_addr_i   = ea;
        tick();
        start_i = 1'b0;
        check("req_rise", 128'(ext_req_o), 128'd1);
        check("busy_rise", 128'(busy_o), 128'd1);
        check("req_addr", 128'(ext_addr_o), 128'(ea));
        check("req_len", 128'(ext_len_o), 128'(num));
        for (int d = 0; d < ack_dly; d++) begin
            if (poke && d == 2) begin
                start_i      = 1'b1;
                base_raddr_i = 6'd5;
                word_num_i   = 7'd3;
                ext_addr_i   = 32'hDEAD_BEEF;
            end
            tick();
            start_i = 1'b0;
            check("req_hold", 128'(ext_req_o), 128'd1);
            check("addr_hold", 128'(ext_addr_o), 128'(ea));
            check("len_hold", 128'(ext_len_o), 128'(num));
        end
        ext_ack_i = 1'b1;
        tick();
        ext_ack_i = 1'b0;
        check("req_drop", 128'(ext_req_o), 128'd0);
        check("first_rd", 128'(rd_o), 128'd1);
        tick();
        check("first_valid", 128'(ext_wvalid_o), 128'd1);
        for (int i = 0; i < 400; i++) begin
            if (done_o) break;
            tick();
        end
        check("done_seen", 128'(done_o), 128'd1);
        check("done_lat", 128'(cyc), 128'(last_hs + 1));
        check("word_count", 128'(hs_cnt), 128'(num));
        if (!bp) check("burst_span", 128'(last_hs - first_hs), 128'(num - 1));
        tick();
        check("done_pulse", 128'(done_o), 128'd0);
        check("busy_fall", 128'(busy_o), 128'd0);
        bp_mode = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // full-speed
        run_drain(0, 8, 32'h0000_1000, 1, 1'b0, 1'b0);
        tick();
        // wrap-around
        run_drain(60, 8, 32'h0000_2000, 1, 1'b0, 1'b0);
        tick();
        // back-pressure
        run_drain(20, 16, 32'h0000_3000, 2, 1'b1, 1'b0);
        tick();

        // zero length
        arm_scoreboard(0, 0);
        start_i    = 1'b1;
        word_num_i = '0;
        tick();
        start_i = 1'b0;
        check("zero_req", 128'(ext_req_o), 128'd0);
        check("zero_rd1", 128'(rd_o), 128'd0);
        check("zero_busy", 128'(busy_o), 128'd1);
        check("zero_done_early", 128'(done_o), 128'd0);
        tick();
        check("zero_done", 128'(done_o), 128'd1);
        check("zero_rd2", 128'(rd_o), 128'd0);
        check("zero_req2", 128'(ext_req_o), 128'd0);
        tick();
        check("zero_done_fall", 128'(done_o), 128'd0);
        check("zero_busy_fall", 128'(busy_o), 128'd0);
        check("zero_words", 128'(hs_cnt), 128'd0);
        tick();

        // busy start ignored, late ack
        run_drain(7, 5, 32'h0000_4000, 10, 1'b0, 1'b1);
        tick();

        // reset mid-burst
        arm_scoreboard(0, 64);
        start_i      = 1'b1;
        base_raddr_i = '0;
        word_num_i   = 7'd64;
        ext_addr_i   = 32'h0000_5000;
        tick();
        start_i   = 1'b0;
        ext_ack_i = 1'b1;
        tick();
        ext_ack_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (hs_cnt >= 3) break;
            tick();
        end
        check("mid_words", 128'(hs_cnt >= 3), 128'd1);
        rst_n = 1'b0;
        tick();
        check_all_zero("midrst");
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        run_drain(10, 4, 32'h0000_6000, 1, 1'b0, 1'b0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
